// File: rtl/comp_refill_engine_if.sv
// rtl/comp_refill_engine_if.sv - miss, memory-read, dictionary-lookup and line-fill signals of the refill engine
interface comp_refill_engine_if #(
  parameter int NUM_BLOCKS = 4,
  parameter int KEY_WIDTH  = 16
);
  logic                            miss_valid;
  logic [31:0]                     miss_addr;
  logic                            miss_ready;
  logic                            comp_en;
  logic                            mem_req_valid;
  logic                            mem_req_ready;
  logic [31:0]                     mem_req_addr;
  logic [31:0]                     mem_req_rdata;
  logic [31:0]                     lkp_word;
  logic                            lkp_hit;
  logic [KEY_WIDTH-1:0]            lkp_key;
  logic                            fill_valid;
  logic                            fill_comp;
  logic [31:0]                     fill_addr;
  logic [32*NUM_BLOCKS-1:0]        fill_line;
  logic [KEY_WIDTH*NUM_BLOCKS-1:0] fill_cline;

  modport master (
    input  miss_valid, miss_addr, comp_en, mem_req_ready, mem_req_rdata, lkp_hit, lkp_key,
    output miss_ready, mem_req_valid, mem_req_addr, lkp_word,
           fill_valid, fill_comp, fill_addr, fill_line, fill_cline
  );

  modport slave (
    output miss_valid, miss_addr, comp_en, mem_req_ready, mem_req_rdata, lkp_hit, lkp_key,
    input  miss_ready, mem_req_valid, mem_req_addr, lkp_word,
           fill_valid, fill_comp, fill_addr, fill_line, fill_cline
  );
endinterface

// File: rtl/comp_refill_engine.sv
// rtl/comp_refill_engine.sv - critical-word-first line refill that also gathers dictionary keys for a compressed copy
// Optional fill counters stat_lines/stat_comp_lines are enabled by defining COMP_REFILL_STATS_EN.
module comp_refill_engine #(
  parameter int NUM_BLOCKS       = 4,
  parameter int KEY_WIDTH        = 16,
  parameter int BYTE_OFFSET_BITS = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  comp_refill_engine_if.master  bus
`ifdef COMP_REFILL_STATS_EN
  ,
  output logic [31:0]           stat_lines,
  output logic [31:0]           stat_comp_lines
`endif
);
  localparam int IDX_W    = $clog2(NUM_BLOCKS);
  localparam int LOW_BITS = IDX_W + BYTE_OFFSET_BITS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FETCH   = 2'd1,
    DELIVER = 2'd2
  } state_t;

  state_t                          r_state;
  logic [IDX_W-1:0]                r_idx;
  logic [IDX_W-1:0]                r_cnt;
  logic                            r_flag;
  logic                            r_miss_ready;
  logic                            r_mem_req_valid;
  logic                            r_fill_valid;
  logic                            r_fill_comp;
  logic [31:0]                     r_fill_addr;
  logic [32*NUM_BLOCKS-1:0]        r_fill_line;
  logic [KEY_WIDTH*NUM_BLOCKS-1:0] r_fill_cline;

  logic [31:0]                     w_base;
  logic [IDX_W-1:0]                w_start_idx;
  logic [31:0]                     w_word_off;

  assign w_base      = bus.miss_addr & ~((32'd1 << LOW_BITS) - 32'd1);
  assign w_start_idx = bus.miss_addr[BYTE_OFFSET_BITS +: IDX_W];
  assign w_word_off  = 32'(r_idx) << BYTE_OFFSET_BITS;

  // fill_addr doubles as the line base while fetching, so it is only reloaded at accept
  assign bus.mem_req_addr  = r_fill_addr | w_word_off;
  assign bus.lkp_word      = bus.mem_req_rdata;
  assign bus.miss_ready    = r_miss_ready;
  assign bus.mem_req_valid = r_mem_req_valid;
  assign bus.fill_valid    = r_fill_valid;
  assign bus.fill_comp     = r_fill_comp;
  assign bus.fill_addr     = r_fill_addr;
  assign bus.fill_line     = r_fill_line;
  assign bus.fill_cline    = r_fill_cline;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state         <= IDLE;
      r_idx           <= '0;
      r_cnt           <= '0;
      r_flag          <= 1'b0;
      r_miss_ready    <= 1'b1;
      r_mem_req_valid <= 1'b0;
      r_fill_valid    <= 1'b0;
      r_fill_comp     <= 1'b0;
      r_fill_addr     <= '0;
      r_fill_line     <= '0;
      r_fill_cline    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.miss_valid && r_miss_ready) begin
            r_state         <= FETCH;
            r_miss_ready    <= 1'b0;
            r_mem_req_valid <= 1'b1;
            r_fill_addr     <= w_base;
            r_idx           <= w_start_idx;
            r_cnt           <= '0;
            r_flag          <= bus.comp_en;
          end
        end
        FETCH: begin
          if (bus.mem_req_ready) begin
            r_fill_line[32*r_idx +: 32]               <= bus.mem_req_rdata;
            r_fill_cline[KEY_WIDTH*r_idx +: KEY_WIDTH] <= bus.lkp_key;
            r_flag <= r_flag & bus.lkp_hit;
            r_idx  <= r_idx + 1'b1;
            r_cnt  <= r_cnt + 1'b1;
            // NUM_BLOCKS is a power of two, so the last beat is an all-ones count
            if (&r_cnt) begin
              r_state         <= DELIVER;
              r_mem_req_valid <= 1'b0;
              r_fill_valid    <= 1'b1;
              r_fill_comp     <= r_flag & bus.lkp_hit;
            end
          end
        end
        DELIVER: begin
          r_state      <= IDLE;
          r_fill_valid <= 1'b0;
          r_fill_comp  <= 1'b0;
          r_miss_ready <= 1'b1;
        end
        default: begin
          r_state         <= IDLE;
          r_miss_ready    <= 1'b1;
          r_mem_req_valid <= 1'b0;
          r_fill_valid    <= 1'b0;
          r_fill_comp     <= 1'b0;
        end
      endcase
    end
  end

`ifdef COMP_REFILL_STATS_EN
  logic [31:0] r_stat_lines;
  logic [31:0] r_stat_comp_lines;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_stat_lines      <= '0;
      r_stat_comp_lines <= '0;
    end else if (r_fill_valid) begin
      r_stat_lines <= r_stat_lines + 32'd1;
      if (r_fill_comp) r_stat_comp_lines <= r_stat_comp_lines + 32'd1;
    end
  end

  assign stat_lines      = r_stat_lines;
  assign stat_comp_lines = r_stat_comp_lines;
`endif
endmodule

// File: doc/comp_refill_engine.md
COMP_REFILL_ENGINE -- requirements
Module: comp_refill_engine

Interface
REQ-001 SHALL have parameter NUM_BLOCKS, default 4: words per line, power of two, at least 2.
REQ-002 SHALL have parameter KEY_WIDTH, default 16: compressed-word width, the sum of dictionary key widths.
REQ-003 SHALL have parameter BYTE_OFFSET_BITS, default 2: byte offset bits per 32-bit word.
REQ-004 SHALL have port clk  in  1: single clock, rising edge.
REQ-005 SHALL have port resetn  in  1: reset, asynchronous and active-low.
REQ-006 SHALL have port miss_valid  in  1: cache miss request.
REQ-007 SHALL have port miss_addr  in  32: missing instruction address.
REQ-008 SHALL have port miss_ready  out  1: request accepted this cycle.
REQ-009 SHALL have port comp_en  in  1: compression mode; sampled at accept.
REQ-010 SHALL have port mem_req_valid  out  1: memory read request.
REQ-011 SHALL have port mem_req_ready  in  1: mem_req_rdata valid this cycle.
REQ-012 SHALL have port mem_req_addr  out  32: word-aligned read address.
REQ-013 SHALL have port mem_req_rdata  in  32: read data.
REQ-014 SHALL have port lkp_word  out  32: word presented to dictionaries; equals mem_req_rdata, combinational.
REQ-015 SHALL have port lkp_hit  in  1: all dictionary fields hit for lkp_word, same cycle.
REQ-016 SHALL have port lkp_key  in  KEY_WIDTH: concatenated dictionary keys for lkp_word, same cycle.
REQ-017 SHALL have port fill_valid  out  1: one-cycle line-delivery pulse.
REQ-018 SHALL have port fill_comp  out  1: line goes to compressed cache (1) or plain cache (0).
REQ-019 SHALL have port fill_addr  out  32: line base address.
REQ-020 SHALL have port fill_line  out  32*NUM_BLOCKS: uncompressed line; word i at bits [32i +: 32].
REQ-021 SHALL have port fill_cline  out  KEY_WIDTH*NUM_BLOCKS: compressed line; word i at bits [KEY_WIDTH*i +: KEY_WIDTH].

Function
REQ-022 SHALL implement FSM IDLE -> FETCH -> DELIVER -> IDLE.
REQ-023 SHALL assert miss_ready only in IDLE; miss_valid & miss_ready moves to FETCH and latches miss_addr and comp_en.
REQ-024 SHALL compute the line base as miss_addr with the low log2(NUM_BLOCKS)+BYTE_OFFSET_BITS bits cleared.
REQ-025 SHALL fetch critical-word-first: first word index equals the miss_addr word offset, then increments modulo NUM_BLOCKS (wrap-around).
REQ-026 SHALL hold mem_req_valid high throughout FETCH; each cycle with mem_req_ready high captures one beat, and mem_req_addr advances to the next word on the following cycle.
REQ-027 SHALL on each beat write mem_req_rdata to fill_line slot i and lkp_key to fill_cline slot i, and AND lkp_hit into a running compressible flag initialised to latched comp_en.
REQ-028 SHALL leave FETCH after exactly NUM_BLOCKS beats, deasserting mem_req_valid the cycle after the last beat.
REQ-029 SHALL in DELIVER pulse fill_valid for exactly one cycle with fill_comp equal to the compressible flag, then return to IDLE.
REQ-030 SHALL hold fill_addr, fill_line and fill_cline stable from DELIVER until the next accept.
REQ-031 SHALL ignore miss_valid outside IDLE; miss latency is NUM_BLOCKS beat cycles plus 2 (one FETCH entry cycle and one DELIVER cycle).
REQ-032 SHALL force fill_comp=0 when latched comp_en=0, regardless of lkp_hit.

Reset
REQ-033 SHALL on resetn low immediately enter IDLE and drive mem_req_valid=0, fill_valid=0, fill_comp=0, and fill_addr, fill_line and fill_cline to 0.
REQ-034 SHALL on reset during FETCH or DELIVER abort the refill with no fill_valid pulse; miss_ready=1 the first cycle after release.

Configuration
REQ-035 SHALL, with COMP_REFILL_STATS_EN defined, add outputs stat_lines (32) and stat_comp_lines (32), counting fill_valid pulses and fill_valid&fill_comp pulses, wrapping modulo 2^32 and reset to 0.
REQ-036 SHALL, without COMP_REFILL_STATS_EN, omit the stat ports and counters entirely.

Verification
REQ-037 SHALL cover: miss_addr=0x100C, comp_en=1, lkp_hit always 1, mem ready every cycle -> mem_req_addr order 0x100C, 0x1000, 0x1004, 0x1008; fill_valid once; fill_comp=1; fill_addr=0x1000.
REQ-038 SHALL cover: miss_addr=0x2000, comp_en=1, lkp_hit=0 on the third beat only -> fill_comp=0 and fill_line holds all 4 words.
REQ-039 SHALL cover: miss_addr=0x3004, comp_en=0, lkp_hit=1 -> fill_comp=0.
REQ-040 SHALL cover: mem_req_ready low 3 cycles between each beat -> mem_req_valid and mem_req_addr stable while waiting; correct slot ordering.
REQ-041 SHALL cover: resetn pulsed low after 2 beats -> no fill_valid; outputs 0; a following miss completes normally.
REQ-042 SHALL cover: with COMP_REFILL_STATS_EN defined, 3 compressible and 2 plain refills -> stat_lines=5 and stat_comp_lines=3.
